// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared FSM state, widths and address-check helper for imem_responder
package imem_responder_pkg;

  localparam int ADDR_W     = 64;
  localparam int LIM_W      = ADDR_W + 1;
  localparam int WORD_W     = 64;
  localparam int INSN_W     = 32;
  localparam int STRB_W     = 8;
  localparam int CNT_W      = 4;
  localparam int WORD_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Limit is one bit wider than the address so base + size never wraps.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [LIM_W-1:0]  limit);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  function automatic logic fetch_fault(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [LIM_W-1:0]  limit);
    return (addr[1:0] != 2'b00) || !addr_in_range(addr, base, limit);
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage, synchronous read port and byte-masked write port
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rd_data_q;

  // Read and write share an edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with access-fault reporting
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter logic [63:0] MEM_BASE    = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [INSN_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [LIM_W-1:0] MEM_LIMIT = {1'b0, MEM_BASE} + (LIM_W'(DEPTH_WORDS) << WORD_SHIFT);
  localparam logic [CNT_W-1:0] LAT_M1    = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              hi_q, hi_d;

  logic              enter_resp;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [WORD_W-1:0] rd_word;
  logic              wr_fire;
  logic [IDX_W-1:0]  wr_idx;

  // With zero latency the read is issued on the accept edge, before addr_q holds the pc.
  assign rd_addr    = (LATENCY == 0) ? req_addr : addr_q;
  assign rd_idx     = IDX_W'((rd_addr - MEM_BASE) >> WORD_SHIFT);
  assign enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == '0));

  assign wr_fire = wr_en && (wr_strb != '0) && addr_in_range(wr_addr, MEM_BASE, MEM_LIMIT);
  assign wr_idx  = IDX_W'((wr_addr - MEM_BASE) >> WORD_SHIFT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    hi_d         = hi_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_err_d   = fetch_fault(rd_addr, MEM_BASE, MEM_LIMIT);
      hi_d         = rd_addr[2];
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      hi_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      hi_q         <= hi_d;
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .rd_en  (enter_resp),
    .rd_idx (rd_idx),
    .rd_data(rd_word),
    .wr_en  (wr_fire),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .wr_strb(wr_strb)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = (resp_valid_q && !resp_err_q) ? (hi_q ? rd_word[63:32] : rd_word[31:0]) : '0;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder (LATENCY 2 and 0 builds)
module tb_imem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] LIMIT = 64'h8000_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] req_addr = '0;
  logic [31:0] resp_data;
  logic        req_valid0 = 1'b0, req_ready0, resp_valid0, resp_ready0 = 1'b1, resp_err0;
  logic [63:0] req_addr0 = '0;
  logic [31:0] resp_data0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = '0, wr_data = '0;
  logic [7:0]  wr_strb = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mm [longint];

  always #5 clk = ~clk;

  imem_responder #(.MEM_BASE(BASE), .DEPTH_WORDS(4096), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb));

  imem_responder #(.MEM_BASE(BASE), .DEPTH_WORDS(4096), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0), .resp_err(resp_err0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb));

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    longint      idx;
    logic [63:0] w;
    if (s == 8'h00 || a < BASE || a >= LIMIT) return;
    idx = longint'((a - BASE) / 8);
    w = mm.exists(idx) ? mm[idx] : 64'hx;
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mm[idx] = w;
  endfunction

  function automatic void model_fetch(input logic [63:0] a, output logic e, output logic [31:0] d);
    logic [63:0] w;
    e = (a % 4 != 0) || (a < BASE) || (a >= LIMIT);
    w = e ? 64'h0 : mm[longint'((a - BASE) / 8)];
    d = e ? 32'h0 : ((a % 8 == 4) ? w[63:32] : w[31:0]);
  endfunction

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r <= 6) return BASE + 64'(8 * $urandom_range(0, 15)) + 64'(4 * $urandom_range(0, 1));
    if (r == 7) return BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
    if (r == 8) return BASE - 64'(4 * $urandom_range(1, 4));
    return LIMIT + 64'(4 * $urandom_range(0, 3));
  endfunction

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic fetch(input logic [63:0] a, input int hold, output int lat, output logic [31:0] d,
                       output logic e, output bit stable, output bit rv_after);
    lat = 0; stable = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    d = resp_data; e = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d || resp_err !== e || req_ready !== 1'b0) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    rv_after = resp_valid;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b data=%h err=%b, want 0/0/0", resp_valid, resp_data, resp_err);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: req_ready=%b req_ready0=%b, want 1", req_ready, req_ready0);
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic e; bit st, rva;
    do_write(BASE, 64'h0000_0073_0010_0093, 8'hFF);
    fetch(BASE, 0, lat, d, e, st, rva);
    n_checks++;
    if (lat !== 3 || d !== 32'h0010_0093 || e !== 1'b0 || rva !== 1'b0) begin
      n_fail++; $display("FAIL basic_lo: lat=%0d data=%h err=%b after=%b, want 3/00100093/0/0", lat, d, e, rva);
    end
    fetch(BASE + 64'd4, 0, lat, d, e, st, rva);
    n_checks++;
    if (lat !== 3 || d !== 32'h0000_0073 || e !== 1'b0 || rva !== 1'b0) begin
      n_fail++; $display("FAIL basic_hi: lat=%0d data=%h err=%b after=%b, want 3/00000073/0/0", lat, d, e, rva);
    end
  endtask

  task automatic test_faults();
    logic [63:0] addrs [6];
    int lat; logic [31:0] d, xd; logic e, xe; bit st, rva;
    do_write(LIMIT - 64'd8, 64'hCAFE_F00D_1234_5678, 8'hFF);
    addrs = '{64'h8000_0002, 64'h7FFF_FFFC, 64'h8000_8000, 64'h8000_7FFC,
              64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0001};
    foreach (addrs[i]) begin
      fetch(addrs[i], 0, lat, d, e, st, rva);
      model_fetch(addrs[i], xe, xd);
      n_checks++;
      if (lat !== 3 || d !== xd || e !== xe) begin
        n_fail++; $display("FAIL fault_%0d addr=%h: lat=%0d data=%h err=%b, want 3/%h/%b", i, addrs[i], lat, d, e, xd, xe);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d; logic e; bit st, rva;
    fetch(BASE, 5, lat, d, e, st, rva);
    n_checks++;
    if (lat !== 3 || st !== 1'b1 || rva !== 1'b0 || d !== 32'h0010_0093) begin
      n_fail++; $display("FAIL backpressure: lat=%0d stable=%b after=%b data=%h, want 3/1/0/00100093", lat, st, rva, d);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_idle: req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_reset_wait();
    int lat, seen; logic [31:0] d, xd; logic e, xe; bit st, rva;
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait_async: valid=%b data=%h err=%b ready=%b, want 0/0/0/1", resp_valid, resp_data, resp_err, req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    resp_ready = 1'b0;
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_wait_ghost: %0d stray responses, want 0", seen);
    end
    fetch(BASE + 64'd4, 0, lat, d, e, st, rva);
    model_fetch(BASE + 64'd4, xe, xd);
    n_checks++;
    if (lat !== 3 || d !== xd || e !== xe) begin
      n_fail++; $display("FAIL reset_wait_next: lat=%0d data=%h err=%b, want 3/%h/%b", lat, d, e, xd, xe);
    end
    // Reset while a response is being held must drop it mid-cycle.
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_async: valid=%b data=%h err=%b, want 0/0/0", resp_valid, resp_data, resp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_collision();
    logic [63:0] a, oldw, neww;
    int lat; logic [31:0] d, xd; logic e, xe; bit st, rva;
    a = BASE + 64'h40;
    oldw = {$urandom, $urandom};
    neww = {$urandom, $urandom};
    do_write(a, oldw, 8'hFF);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = neww; wr_strb = 8'h0F;
    @(posedge clk);
    #1 wr_en = 1'b0;
    model_write(a, neww, 8'h0F);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== oldw[31:0]) begin
      n_fail++; $display("FAIL collision_old: valid=%b data=%h, want 1/%h", resp_valid, resp_data, oldw[31:0]);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    fetch(a, 0, lat, d, e, st, rva);
    model_fetch(a, xe, xd);
    n_checks++;
    if (d !== neww[31:0] || d !== xd || e !== 1'b0) begin
      n_fail++; $display("FAIL collision_new: data=%h err=%b, want %h/0", d, e, neww[31:0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    int lat, hold; logic [31:0] d, xd; logic e, xe; bit st, rva;
    for (int w = 0; w < 16; w++) do_write(BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? LIMIT + 64'(8 * $urandom_range(0, 15)) : BASE + 64'(8 * $urandom_range(0, 15));
        do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      end
      a = rand_addr();
      hold = $urandom_range(0, 3);
      fetch(a, hold, lat, d, e, st, rva);
      model_fetch(a, xe, xd);
      n_checks++;
      if (lat !== 3 || d !== xd || e !== xe || st !== 1'b1 || rva !== 1'b0) begin
        n_fail++; $display("FAIL random_%0d addr=%h: lat=%0d data=%h err=%b stable=%b after=%b, want 3/%h/%b/1/0", n, a, lat, d, e, st, rva, xd, xe);
      end
    end
  endtask

  task automatic test_back_to_back_lat0();
    logic [63:0] q [$];
    logic [63:0] a;
    logic [31:0] xd; logic xe;
    int acc = 0, rsp = 0;
    resp_ready0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b1; req_addr0 = rand_addr();
    for (int c = 0; c < 24; c++) begin
      n_checks++;
      if (req_ready0 !== (c % 2 == 0) || resp_valid0 !== (c % 2 == 1)) begin
        n_fail++; $display("FAIL lat0_cycle_%0d: ready=%b valid=%b, want %b/%b", c, req_ready0, resp_valid0, c % 2 == 0, c % 2 == 1);
      end
      if (resp_valid0 === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL lat0_extra_resp_%0d: response with nothing outstanding", c);
        end else begin
          a = q.pop_front();
          model_fetch(a, xe, xd);
          n_checks++;
          rsp++;
          if (resp_data0 !== xd || resp_err0 !== xe) begin
            n_fail++; $display("FAIL lat0_data_%0d addr=%h: data=%h err=%b, want %h/%b", c, a, resp_data0, resp_err0, xd, xe);
          end
        end
      end
      if (req_ready0 === 1'b1) begin
        q.push_back(req_addr0);
        acc++;
      end else begin
        req_addr0 = rand_addr();
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (acc !== 12 || rsp !== 12 || resp_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL lat0_throughput: accepts=%0d responses=%0d valid=%b, want 12/12/0", acc, rsp, resp_valid0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faults();
    test_backpressure();
    test_reset_wait();
    test_write_collision();
    test_random();
    test_back_to_back_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter MEM_BASE, default 64'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, number of 64-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, wait cycles between request accept and response (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  64  fetch byte address (the pc).
REQ-009 SHALL have port resp_valid  output  1  response present.
REQ-010 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-011 SHALL have port resp_data  output  32  fetched instruction.
REQ-012 SHALL have port resp_err  output  1  access fault flag, valid with resp_valid.
REQ-013 SHALL have ports wr_en  input  1 / wr_addr  input  64 / wr_data  input  64 / wr_strb  input  8  byte-masked preload write.

Function
REQ-014 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 Request handshake (req_valid & req_ready) SHALL latch req_addr and go to WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-016 WAIT SHALL load a 4-bit counter with LATENCY-1 on accept, decrement each cycle, enter RESP on the cycle after it reads 0.
REQ-017 resp_valid SHALL rise exactly LATENCY+1 cycles after the accept edge.
REQ-018 Storage read SHALL occur on the transition into RESP; index = (addr - MEM_BASE) >> 3, width log2(DEPTH_WORDS).
REQ-019 resp_data SHALL be word[63:32] when latched addr[2]=1, else word[31:0].
REQ-020 resp_err SHALL be 1 and resp_data 0 when addr[1:0] != 0, addr < MEM_BASE, or addr >= MEM_BASE + DEPTH_WORDS*8 (full 64-bit compare, no wrap).
REQ-021 In RESP, resp_valid, resp_data, resp_err SHALL hold stable until resp_ready; handshake returns to IDLE, resp_valid low next cycle.
REQ-022 No request SHALL be accepted in the same cycle as a response handshake; max throughput one fetch per LATENCY+2 cycles.
REQ-023 wr_en SHALL write bytes of wr_data selected by wr_strb into word (wr_addr - MEM_BASE) >> 3 in any state; out-of-range or wr_strb=0 writes SHALL be ignored.
REQ-024 A write to the word being read on the RESP-entry edge SHALL not affect that response (old data returned).

Reset
REQ-025 Reset assertion SHALL force IDLE, resp_valid 0, resp_data 0, resp_err 0, counter 0 immediately, without waiting for clk.
REQ-026 Reset mid-transaction SHALL discard it; no response SHALL ever be issued for it.
REQ-027 Storage contents SHALL not be reset; req_ready SHALL be 1 from the first cycle after deassertion.

Structure
REQ-028 Shared package SHALL hold the FSM state enum (IDLE/WAIT/RESP) and address-check widths/constants.
REQ-029 Storage SHALL be sub-module imem_array (synchronous read, byte-masked write port).

Verification
REQ-030 Preload 0x8000_0000 = 64'h0000_0073_0010_0093, LATENCY=2; fetch 0x8000_0000 then 0x8000_0004 -> resp_data 32'h0010_0093 then 32'h0000_0073, resp_valid 3 cycles after each accept.
REQ-031 Fetch 0x8000_0002, then 0x7FFF_FFFC, then 0x8000_8000 -> resp_err 1, resp_data 0 each time.
REQ-032 Hold resp_ready low 5 cycles -> resp_valid/data stable, req_ready 0 throughout; accept on cycle 6, return to IDLE.
REQ-033 Assert reset during WAIT -> outputs zero asynchronously, no resp_valid after release, next request served normally.
REQ-034 wr_strb=8'h0F to word under read on RESP-entry edge -> old data returned; refetch returns new low word.
REQ-035 LATENCY=0 build: back-to-back fetches with resp_ready tied 1 -> resp_valid 1 cycle after each accept, one fetch per 2 cycles.
